// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4-to-1 operand mux between four requesters,
// delivering beats to one consumer over valid/ready with capped bursts.
module mux_rr_arbiter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    input  logic [WIDTH-1:0] data_d,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic [3:0]       ack,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       r_last_winner;
    logic [1:0]       w_last_winner_nxt;
    logic [3:0]       r_grant;
    logic [3:0]       w_grant_nxt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_beat_cnt_nxt;

    logic             w_found;
    logic [1:0]       w_winner;
    logic [1:0]       w_cand;
    logic [WIDTH-1:0] w_mux;
    logic             w_valid;
    logic             w_hs;

    // Search starts just after the previous winner and ends on it.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_winner;
        w_cand   = r_last_winner;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_cand = r_last_winner + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_mux = '0;
        case (r_sel)
            2'd0:    w_mux = data_a;
            2'd1:    w_mux = data_b;
            2'd2:    w_mux = data_c;
            default: w_mux = data_d;
        endcase
    end

    // A beat presented during reset is aborted, so it can never be handshaken.
    assign w_valid = (r_state == ST_XFER) && req[r_sel] && !rst;
    assign w_hs    = w_valid && out_ready;

    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_grant_nxt       = r_grant;
        w_last_winner_nxt = r_last_winner;
        w_beat_cnt_nxt    = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt       = ST_XFER;
                    w_sel_nxt         = w_winner;
                    w_grant_nxt       = 4'b0001 << w_winner;
                    w_last_winner_nxt = w_winner;
                    w_beat_cnt_nxt    = '0;
                end
            end
            ST_XFER: begin
                if (!req[r_sel]) begin
                    w_state_nxt    = ST_IDLE;
                    w_grant_nxt    = '0;
                    w_beat_cnt_nxt = '0;
                end else if (w_hs) begin
                    if (last[r_sel] || (r_beat_cnt == CNT_LAST)) begin
                        w_state_nxt    = ST_IDLE;
                        w_grant_nxt    = '0;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_grant       <= '0;
            r_last_winner <= 2'd3;
            r_beat_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_grant       <= w_grant_nxt;
            r_last_winner <= w_last_winner_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
        end
    end

    assign busy      = (r_state == ST_XFER);
    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_mux : '0;
    assign sel       = r_sel;
    assign grant     = r_grant;
    assign ack       = r_grant & {4{w_hs}};

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural round-robin model.
module tb_mux_rr_arbiter;

    localparam int MAXB = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] data_a, data_b, data_c, data_d;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] sel;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;

    mux_rr_arbiter #(.WIDTH(4), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .sel(sel), .grant(grant), .ack(ack), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] da, db, dc, dd;
        logic       ev;
        logic [3:0] ed;
        logic [3:0] eg;
        logic [1:0] es;
        logic [3:0] ea;
        logic       eb;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; req = v.req; last = v.last; out_ready = v.rdy;
        data_a = v.da; data_b = v.db; data_c = v.dc; data_d = v.dd;
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'(v.ev));
        check({tag, ".data"},  32'(out_data),  32'(v.ed));
        check({tag, ".grant"}, 32'(grant),     32'(v.eg));
        check({tag, ".sel"},   32'(sel),       32'(v.es));
        check({tag, ".ack"},   32'(ack),       32'(v.ea));
        check({tag, ".busy"},  32'(busy),      32'(v.eb));
    endtask

    // Behavioural model: owner index (-1 when idle), last winner, beats delivered.
    int         m_owner, m_lw, m_beats, m_sel;
    logic [3:0] dv[4];
    logic       e_busy, e_valid;
    logic [3:0] e_data, e_grant, e_ack;

    initial begin
        rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;
        data_a = '0; data_b = '0; data_c = '0; data_d = '0;
        repeat (2) @(posedge clk);

        // Single requester, then round-robin over four continuous requesters.
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 4'h2, 4'h2, 1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 4'h2, 4'h2, 1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 1'b1, 4'h9, 4'h2, 2'd1, 4'h2, 1'b1};
        tbl[3]  = '{1'b0, 4'h0, 4'h2, 1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd1, 4'h0, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 2'd1, 4'h0, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'h1, 4'h1, 2'd0, 4'h1, 1'b1};
        tbl[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'h2, 4'h2, 2'd1, 4'h2, 1'b1};
        tbl[9]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 2'd1, 4'h0, 1'b0};
        tbl[10] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'h3, 4'h4, 2'd2, 4'h4, 1'b1};
        tbl[11] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 2'd2, 4'h0, 1'b0};
        tbl[12] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'h4, 4'h8, 2'd3, 4'h8, 1'b1};
        tbl[13] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 2'd3, 4'h0, 1'b0};
        tbl[14] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'h1, 4'h1, 2'd0, 4'h1, 1'b1};
        tbl[15] = '{1'b0, 4'h0, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0};
        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Burst cap: four beats without last, then forced rotation back to A.
        apply(vec_t'{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0}, "cap.rst");
        apply(vec_t'{1'b0, 4'h1, 4'h0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0}, "cap.req");
        for (int i = 1; i <= 4; i++)
            apply(vec_t'{1'b0, 4'h1, 4'h0, 1'b1, 4'(i), 4'h0, 4'h0, 4'h0, 1'b1, 4'(i), 4'h1, 2'd0, 4'h1, 1'b1},
                  $sformatf("cap.beat%0d", i));
        apply(vec_t'{1'b0, 4'h1, 4'h0, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0}, "cap.bubble");
        apply(vec_t'{1'b0, 4'h1, 4'h1, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b1, 4'h5, 4'h1, 2'd0, 4'h1, 1'b1}, "cap.regrant");

        // Backpressure on C: data held, ack only once ready rises.
        apply(vec_t'{1'b0, 4'h4, 4'h4, 1'b0, 4'h0, 4'h0, 4'h6, 4'h0, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0}, "bp.req");
        for (int i = 0; i < 3; i++)
            apply(vec_t'{1'b0, 4'h4, 4'h4, 1'b0, 4'h0, 4'h0, 4'h6, 4'h0, 1'b1, 4'h6, 4'h4, 2'd2, 4'h0, 1'b1},
                  $sformatf("bp.stall%0d", i));
        apply(vec_t'{1'b0, 4'h4, 4'h4, 1'b1, 4'h0, 4'h0, 4'h6, 4'h0, 1'b1, 4'h6, 4'h4, 2'd2, 4'h4, 1'b1}, "bp.accept");

        // Early release by D after one beat; pending A wins next.
        apply(vec_t'{1'b0, 4'h8, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h7, 1'b0, 4'h0, 4'h0, 2'd2, 4'h0, 1'b0}, "rel.req");
        apply(vec_t'{1'b0, 4'h8, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h7, 1'b1, 4'h7, 4'h8, 2'd3, 4'h8, 1'b1}, "rel.beat0");
        apply(vec_t'{1'b0, 4'h1, 4'h0, 1'b1, 4'h5, 4'h0, 4'h0, 4'h7, 1'b0, 4'h0, 4'h8, 2'd3, 4'h0, 1'b1}, "rel.drop");
        apply(vec_t'{1'b0, 4'h1, 4'h1, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd3, 4'h0, 1'b0}, "rel.idle");
        apply(vec_t'{1'b0, 4'h1, 4'h1, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b1, 4'h5, 4'h1, 2'd0, 4'h1, 1'b1}, "rel.grantA");

        // Reset while B holds a valid beat: no ack, then fresh arbitration from A.
        apply(vec_t'{1'b0, 4'h2, 4'h0, 1'b0, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0}, "mrst.req");
        apply(vec_t'{1'b0, 4'h2, 4'h0, 1'b0, 4'h0, 4'h9, 4'h0, 4'h0, 1'b1, 4'h9, 4'h2, 2'd1, 4'h0, 1'b1}, "mrst.valid");
        apply(vec_t'{1'b1, 4'h2, 4'h0, 1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0, 4'h0, 4'h2, 2'd1, 4'h0, 1'b1}, "mrst.rst");
        apply(vec_t'{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0}, "mrst.after");
        apply(vec_t'{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'h1, 4'h1, 2'd0, 4'h1, 1'b1}, "mrst.grantA");

        // Randomized traffic against the model, starting from a known reset.
        apply(vec_t'{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0}, "rnd.rst");
        m_owner = -1; m_lw = 3; m_beats = 0; m_sel = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            last      = 4'($urandom) & 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            data_a = 4'($urandom); data_b = 4'($urandom);
            data_c = 4'($urandom); data_d = 4'($urandom);
            #1;
            dv[0] = data_a; dv[1] = data_b; dv[2] = data_c; dv[3] = data_d;
            e_busy  = (m_owner >= 0);
            e_valid = e_busy && req[m_owner] && !rst;
            e_data  = e_valid ? dv[m_owner] : 4'h0;
            e_grant = e_busy ? 4'(1 << m_owner) : 4'h0;
            e_ack   = (e_valid && out_ready) ? e_grant : 4'h0;
            check("rnd.valid", 32'(out_valid), 32'(e_valid));
            check("rnd.data",  32'(out_data),  32'(e_data));
            check("rnd.grant", 32'(grant),     32'(e_grant));
            check("rnd.sel",   32'(sel),       32'(m_sel));
            check("rnd.ack",   32'(ack),       32'(e_ack));
            check("rnd.busy",  32'(busy),      32'(e_busy));
            if (rst) begin
                m_owner = -1; m_lw = 3; m_beats = 0; m_sel = 0;
            end else if (m_owner < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (m_owner < 0 && req[(m_lw + k) % 4]) begin
                        m_owner = (m_lw + k) % 4;
                        m_lw    = m_owner;
                        m_sel   = m_owner;
                        m_beats = 0;
                    end
                end
            end else if (!req[m_owner]) begin
                m_owner = -1; m_beats = 0;
            end else if (out_ready) begin
                m_beats++;
                if (last[m_owner] || m_beats == MAXB) begin
                    m_owner = -1; m_beats = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 4-bit 4-to-1 operand mux between four requesters (A, B, C, D).
- Drives the mux select and a one-hot grant.
- Presents the selected operand to a single downstream consumer (ALU input stage) over a valid/ready handshake.
- Supports multi-beat bursts capped at MAX_BURST beats per grant.

Parameters:
- WIDTH, 4, data width of each requester and of out_data.
- MAX_BURST, 4, maximum beats per grant before forced rotation; legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  4  per-requester "data available now"; bit i = requester i (0=A, 1=B, 2=C, 3=D).
- last  input  4  per-requester "current beat is final beat of burst".
- data_a  input  WIDTH  requester 0 operand.
- data_b  input  WIDTH  requester 1 operand.
- data_c  input  WIDTH  requester 2 operand.
- data_d  input  WIDTH  requester 3 operand.
- out_ready  input  1  consumer accepts beat.
- out_valid  output  1  beat on out_data is valid.
- out_data  output  WIDTH  selected operand.
- sel  output  2  mux select, registered.
- grant  output  4  one-hot current owner, registered.
- ack  output  4  one-cycle pulse on grant bit when that requester's beat is accepted.
- busy  output  1  high while in XFER.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on rising clk.
- Reset values (also applied on rst mid-burst, no ack issued for the aborted beat):
  - State IDLE; grant=0; sel=0; beat_cnt=0; last_winner=3.
  - out_valid=0; out_data=0; ack=0; busy=0.
- State IDLE:
  - busy=0, out_valid=0, grant=0.
  - If any req bit high: winner = first requester with req high, searching last_winner+1, +2, +3, then last_winner itself (mod 4).
  - Next edge: sel<=winner, grant<=onehot(winner), last_winner<=winner, beat_cnt<=0, state<=XFER.
  - Else stay in IDLE.
- State XFER:
  - busy=1.
  - out_valid = req[sel], combinational.
  - out_data = mux(data_a..data_d, sel) when out_valid, else 0; combinational.
  - Handshake = out_valid & out_ready.
  - ack = grant & {4{handshake}}, combinational, one cycle per beat.
- XFER transitions, evaluated at each edge in priority order:
  1. req[sel]=0: release. state<=IDLE, grant<=0, beat_cnt<=0.
  2. Handshake with last[sel]=1, or with beat_cnt=MAX_BURST-1: burst end. state<=IDLE, grant<=0, beat_cnt<=0.
  3. Handshake otherwise: beat_cnt<=beat_cnt+1, stay in XFER with the same owner.
  4. No handshake (out_ready low): hold everything. Data and sel must remain stable.
- Requester contract:
  - Hold data stable while its grant is high and its beat is not yet acked.
  - Update data on the edge where its ack is high.
- Timing:
  - Latency req→out_valid: 1 cycle from IDLE.
  - Every burst end costs one IDLE bubble before the next grant.
- beat_cnt: width clog2(MAX_BURST), minimum 1. Never exceeds MAX_BURST-1.
- MAX_BURST=1: every handshake ends the burst.
- Fairness: a continuously requesting requester waits at most 3 bursts between grants.
- Simultaneous events:
  - Changes to req bits of non-owners during XFER are ignored until the next IDLE.
  - req[sel] dropping in the same cycle as out_ready high: no handshake, release (rule 1).
- Invariants:
  - grant is zero or one-hot; sel always equals the index of the set grant bit.

Test Plan:
1. Reset then single requester: req=0010, data_b=4'h9, last=0010, out_ready=1. Grant=0010 and sel=01 one cycle after req. out_valid=1, out_data=9, ack=0010 for exactly one cycle. Next cycle IDLE, grant=0.
2. Round-robin fairness: req=1111 held, last=1111, out_ready=1. Grant sequence after reset is 0001, 0010, 0100, 1000, 0001. Each grant lasts one cycle, separated by one IDLE cycle.
3. Burst cap: MAX_BURST=4, req=0001, last=0, out_ready=1, data_a stepping 1,2,3,4,5 on each ack. Exactly 4 acks with out_data 1,2,3,4, then IDLE. Regrant to A delivers 5.
4. Backpressure: granted C (data_c=4'h6), out_ready=0 for 3 cycles, then 1. out_valid=1 with out_data=6 stable throughout. ack only in the out_ready=1 cycle. beat_cnt unchanged while stalled.
5. Early release: granted D mid-burst (beat_cnt=1), req[3] drops. Next cycle IDLE, grant=0, no ack. Pending req=0001 is then granted with sel=00.
6. Reset mid-burst: B granted with out_valid=1, assert rst for one cycle with out_ready=1. No ack. All outputs at reset values next cycle. First post-reset grant with req=1111 goes to A (0001).
